// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback for the 4-state (K=3) Viterbi decoder.
// Stores one frame of ACS decisions, traces back from state 0, streams bits.
module viterbi_traceback #(
    parameter int FRAME = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic acs0,
    input  logic acs1,
    input  logic acs2,
    input  logic acs3,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last
);

    localparam int PW = $clog2(FRAME);
    localparam logic [PW-1:0] LAST = PW'(FRAME - 1);

    typedef enum logic [1:0] {
        FILL,
        TRACE,
        OUTPUT
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   tb_idx_q, tb_idx_d;
    logic [1:0]      tb_state_q, tb_state_d;

    logic [3:0]      mem_q [FRAME];
    logic            bitbuf_q [FRAME];

    logic            mem_we;
    logic            bitbuf_we;
    logic            dec;

    assign dec = mem_q[tb_idx_q][tb_state_q];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tb_idx_d   = tb_idx_q;
        tb_state_d = tb_state_q;
        mem_we     = 1'b0;
        bitbuf_we  = 1'b0;
        in_ready   = (state_q == FILL);
        out_valid  = (state_q == OUTPUT);
        out_last   = (state_q == OUTPUT) && (rd_ptr_q == LAST);
        out_bit    = (state_q == OUTPUT) ? bitbuf_q[rd_ptr_q] : 1'b0;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == LAST) begin
                        state_d    = TRACE;
                        wr_ptr_d   = '0;
                        tb_idx_d   = LAST;
                        // zero-terminated trellis always ends in state 0
                        tb_state_d = 2'd0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            TRACE: begin
                bitbuf_we  = 1'b1;
                tb_state_d = {dec, tb_state_q[1]};
                if (tb_idx_q == '0) begin
                    state_d  = OUTPUT;
                    rd_ptr_d = '0;
                end else begin
                    tb_idx_d = tb_idx_q - 1'b1;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    if (rd_ptr_q == LAST) begin
                        state_d  = FILL;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tb_idx_q   <= '0;
            tb_state_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tb_idx_q   <= tb_idx_d;
            tb_state_q <= tb_state_d;
        end
    end

    // Storage is left unreset; contents are rewritten every frame.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[wr_ptr_q] <= {acs3, acs2, acs1, acs0};
        end
        if (bitbuf_we && !reset) begin
            bitbuf_q[tb_idx_q] <= tb_state_q[0];
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Randomised bench for viterbi_traceback against a path-reconstruction model.
// A FRAME=4 instance covers the small hand-worked trellis.
module tb_viterbi_traceback;

    typedef logic [3:0] frame_t [16];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [3:0] acs = 4'd0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic out_bit;
    logic out_last;

    logic v4 = 1'b0;
    logic ir4;
    logic [3:0] a4 = 4'd0;
    logic ov4;
    logic or4 = 1'b1;
    logic ob4;
    logic ol4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    viterbi_traceback #(.FRAME(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .acs0(acs[0]), .acs1(acs[1]), .acs2(acs[2]), .acs3(acs[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_last(out_last)
    );

    viterbi_traceback #(.FRAME(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(v4), .in_ready(ir4),
        .acs0(a4[0]), .acs1(a4[1]), .acs2(a4[2]), .acs3(a4[3]),
        .out_valid(ov4), .out_ready(or4),
        .out_bit(ob4), .out_last(ol4)
    );

    // Walk the survivor path backwards from state 0 using the trellis rules:
    // decoded bit is s[0], predecessor is {decision, s[1]}.
    function automatic logic [15:0] model(input frame_t w);
        logic [1:0] s;
        logic [15:0] b;
        logic d;
        s = 2'd0;
        b = '0;
        for (int i = 15; i >= 0; i--) begin
            b[i] = s[0];
            d = w[i][s];
            s = {d, s[1]};
        end
        return b;
    endfunction

    function automatic frame_t rand_frame();
        frame_t w;
        foreach (w[i]) w[i] = 4'($urandom_range(0, 15));
        return w;
    endfunction

    task automatic send_frame(input frame_t w, input bit gaps,
                              output int fill_not_ready);
        int cnt;
        bit acc;
        cnt = 0;
        fill_not_ready = 0;
        for (int it = 0; it < 400 && cnt < 16; it++) begin
            @(negedge clk);
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            acs = in_valid ? w[cnt] : 4'($urandom_range(0, 15));
            if (!in_ready) fill_not_ready++;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) cnt++;
        end
        if (cnt != 16) fill_not_ready += 1000;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
    task automatic collect(input int mode, input bit junk,
                           output logic [15:0] bits, output logic [15:0] lasts,
                           output int nb, output int first_v,
                           output int ready_low, output int unstable,
                           output int early, output logic rdy_after,
                           output bit tmo);
        bit done, prev_stall;
        logic pb, pl;
        bits = '0; lasts = '0; nb = 0; first_v = -1; ready_low = 0;
        unstable = 0; early = 0; rdy_after = 1'b0; tmo = 1'b1;
        done = 0; prev_stall = 0; pb = 0; pl = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) begin
                rdy_after = in_ready;
                in_valid = 1'b0;
                tmo = 1'b0;
                break;
            end
            case (mode)
                1: out_ready = (k % 3 == 0);
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            in_valid = junk;
            if (junk) acs = 4'($urandom_range(0, 15));
            if (!in_ready) ready_low++;
            else early++;
            if (out_valid && first_v < 0) first_v = k;
            if (out_valid && prev_stall && (out_bit !== pb || out_last !== pl))
                unstable++;
            if (out_valid && out_ready) begin
                if (nb < 16) begin
                    bits[nb] = out_bit;
                    lasts[nb] = out_last;
                end
                nb++;
                if (out_last) done = 1;
            end
            prev_stall = out_valid && !out_ready;
            pb = out_bit;
            pl = out_last;
            @(posedge clk);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_bit !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b bit=%b last=%b, want 1 0 0 0",
                     in_ready, out_valid, out_bit, out_last);
        end
        checks++;
        if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs4: rdy=%b vld=%b, want 1 0", ir4, ov4);
        end
        reset = 1'b0;
    endtask

    task automatic run_and_check(input string name, input frame_t w,
                                 input bit gaps, input int mode, input bit junk,
                                 input bit check_timing);
        logic [15:0] bits, lasts, exp;
        int nb, fv, rl, un, ea, fnr;
        logic rdy;
        bit tmo;
        exp = model(w);
        send_frame(w, gaps, fnr);
        collect(mode, junk, bits, lasts, nb, fv, rl, un, ea, rdy, tmo);
        checks++;
        if (fnr != 0) begin
            errors++;
            $display("FAIL %s_fill: in_ready low/not accepted count=%0d, want 0", name, fnr);
        end
        checks++;
        if (tmo || nb != 16) begin
            errors++;
            $display("FAIL %s_count: got %0d bits timeout=%0d, want 16", name, nb, tmo);
        end
        checks++;
        if (bits !== exp) begin
            errors++;
            $display("FAIL %s_bits: got %h, want %h", name, bits, exp);
        end
        checks++;
        if (lasts !== 16'h8000) begin
            errors++;
            $display("FAIL %s_last: got %h, want 8000", name, lasts);
        end
        checks++;
        if (un != 0 || ea != 0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s_hold: unstable=%0d early_ready=%0d ready_after=%b, want 0 0 1",
                     name, un, ea, rdy);
        end
        checks++;
        if (fv != 16) begin
            errors++;
            $display("FAIL %s_latency: first out_valid at %0d, want 16", name, fv);
        end
        if (check_timing) begin
            checks++;
            if (rl != 32) begin
                errors++;
                $display("FAIL %s_busy: in_ready low %0d cycles, want 32", name, rl);
            end
        end
    endtask

    task automatic test_all_zero();
        frame_t w;
        foreach (w[i]) w[i] = 4'h0;
        run_and_check("zero", w, 0, 0, 0, 1);
    endtask

    task automatic test_all_one();
        frame_t w;
        foreach (w[i]) w[i] = 4'hF;
        checks++;
        if (model(w) !== 16'h3FFF) begin
            errors++;
            $display("FAIL ones_model: got %h, want 3fff", model(w));
        end
        run_and_check("ones", w, 0, 0, 0, 1);
    endtask

    task automatic test_mixed4();
        logic [3:0] w4 [4];
        logic [3:0] bits, lasts;
        int nb;
        w4[0] = 4'b0000; w4[1] = 4'b0000; w4[2] = 4'b0001; w4[3] = 4'b0000;
        bits = '0; lasts = '0; nb = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v4 = 1'b1;
            a4 = w4[i];
            @(posedge clk);
        end
        @(negedge clk);
        v4 = 1'b0;
        for (int k = 0; k < 40 && nb < 4; k++) begin
            if (ov4) begin
                bits[nb] = ob4;
                lasts[nb] = ol4;
                nb++;
            end
            @(negedge clk);
        end
        checks++;
        if (nb != 4 || bits !== 4'b0001 || lasts !== 4'b1000) begin
            errors++;
            $display("FAIL mixed4: n=%0d bits=%b last=%b, want 4 0001 1000", nb, bits, lasts);
        end
    endtask

    task automatic test_backpressure();
        run_and_check("bp", rand_frame(), 0, 1, 0, 0);
    endtask

    task automatic test_gaps_drops();
        run_and_check("gap", rand_frame(), 1, 0, 1, 1);
        run_and_check("after_drop", rand_frame(), 1, 2, 1, 0);
    endtask

    task automatic test_reset_mid();
        frame_t w;
        int fnr, seen;
        send_frame(rand_frame(), 0, fnr);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: rdy=%b vld=%b, want 0 0", in_ready, out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_post: rdy=%b vld=%b last=%b, want 1 0 0",
                     in_ready, out_valid, out_last);
        end
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_idle: %0d cycles busy/valid after reset, want 0", seen);
        end
        foreach (w[i]) w[i] = 4'hF;
        run_and_check("midrst_ones", w, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) run_and_check("b2b", rand_frame(), 0, 2, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_zero();
        test_all_one();
        test_mixed4();
        test_backpressure();
        test_gaps_drops();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
